// File: rtl/aes_dec.sv
// Iterative AES-256 inverse cipher: on-chip key expansion into 15 round-key
// registers, then one decryption round per clock.
//
//   state | meaning
//   IDLE  | waiting for a key and/or ciphertext strobe
//   KEXP  | expanding rk2..rk14, one round key per edge
//   INIT  | initial AddRoundKey with rk14
//   ROUND | inverse rounds 13..1, final round at 0 updates outData
module aes_dec (
    input  logic         inClk,
    input  logic         inRstN,
    input  logic         inKeyWr,
    input  logic [255:0] inKeyData,
    input  logic         inDataWr,
    input  logic [127:0] inDataData,
    output logic [127:0] outData,
    output logic         outBusy,
    output logic         outValid
);

    typedef enum logic [1:0] {IDLE, KEXP, INIT, ROUND} state_t;

    state_t       fsm;
    logic [127:0] rk [15];
    logic [127:0] st;
    logic [3:0]   kcnt;
    logic [3:0]   rnd;
    logic         pending;

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [7:0] gf_mul(input logic [7:0] a, input logic [7:0] b);
        logic [7:0] p;
        logic [7:0] x;
        p = '0;
        x = a;
        for (int i = 0; i < 8; i++) begin
            if (b[i]) p = p ^ x;
            x = xtime(x);
        end
        return p;
    endfunction

    // a^254 is the multiplicative inverse in GF(2^8), and maps 0 to 0
    function automatic logic [7:0] gf_inv(input logic [7:0] a);
        logic [7:0] sq;
        logic [7:0] acc;
        sq  = a;
        acc = 8'h01;
        for (int i = 1; i < 8; i++) begin
            sq  = gf_mul(sq, sq);
            acc = gf_mul(acc, sq);
        end
        return acc;
    endfunction

    function automatic logic [7:0] sbox(input logic [7:0] a);
        logic [7:0] x;
        x = gf_inv(a);
        return x ^ {x[6:0], x[7]} ^ {x[5:0], x[7:6]} ^ {x[4:0], x[7:5]}
                 ^ {x[3:0], x[7:4]} ^ 8'h63;
    endfunction

    function automatic logic [7:0] inv_sbox(input logic [7:0] s);
        logic [7:0] y;
        y = {s[6:0], s[7]} ^ {s[4:0], s[7:5]} ^ {s[1:0], s[7:2]} ^ 8'h05;
        return gf_inv(y);
    endfunction

    function automatic logic [31:0] sub_word(input logic [31:0] w);
        return {sbox(w[31:24]), sbox(w[23:16]), sbox(w[15:8]), sbox(w[7:0])};
    endfunction

    function automatic logic [127:0] inv_sub_bytes(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int n = 0; n < 16; n++)
            o[127-8*n -: 8] = inv_sbox(s[127-8*n -: 8]);
        return o;
    endfunction

    // Byte n of the block is row n%4, column n/4
    function automatic logic [127:0] inv_shift_rows(input logic [127:0] s);
        logic [127:0] o;
        o = '0;
        for (int c = 0; c < 4; c++)
            for (int r = 0; r < 4; r++)
                o[127-8*(4*c+r) -: 8] = s[127-8*(4*((c-r+4)%4)+r) -: 8];
        return o;
    endfunction

    function automatic logic [127:0] inv_mix_columns(input logic [127:0] s);
        logic [127:0] o;
        logic [7:0]   a0, a1, a2, a3;
        o = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = s[127-32*c -: 8];
            a1 = s[119-32*c -: 8];
            a2 = s[111-32*c -: 8];
            a3 = s[103-32*c -: 8];
            o[127-32*c -: 8] = gf_mul(a0, 8'h0e) ^ gf_mul(a1, 8'h0b) ^ gf_mul(a2, 8'h0d) ^ gf_mul(a3, 8'h09);
            o[119-32*c -: 8] = gf_mul(a0, 8'h09) ^ gf_mul(a1, 8'h0e) ^ gf_mul(a2, 8'h0b) ^ gf_mul(a3, 8'h0d);
            o[111-32*c -: 8] = gf_mul(a0, 8'h0d) ^ gf_mul(a1, 8'h09) ^ gf_mul(a2, 8'h0e) ^ gf_mul(a3, 8'h0b);
            o[103-32*c -: 8] = gf_mul(a0, 8'h0b) ^ gf_mul(a1, 8'h0d) ^ gf_mul(a2, 8'h09) ^ gf_mul(a3, 8'h0e);
        end
        return o;
    endfunction

    logic [127:0] rk_prev2, rk_prev1;
    logic [31:0]  kx_word, kw0, kw1, kw2, kw3;
    logic [7:0]   rcon;

    // rk[i] is built from rk[i-2] and rk[i-1]; even i applies RotWord and Rcon
    always_comb begin
        rk_prev2 = rk[kcnt - 4'd2];
        rk_prev1 = (kcnt == 4'd0) ? rk[0] : rk[kcnt - 4'd1];
        rcon     = 8'h01 << (kcnt[3:1] - 3'd1);
        if (!kcnt[0])
            kx_word = sub_word({rk_prev1[23:0], rk_prev1[31:24]}) ^ {rcon, 24'h000000};
        else
            kx_word = sub_word(rk_prev1[31:0]);
        kw0 = rk_prev2[127:96] ^ kx_word;
        kw1 = rk_prev2[95:64]  ^ kw0;
        kw2 = rk_prev2[63:32]  ^ kw1;
        kw3 = rk_prev2[31:0]   ^ kw2;
    end

    logic [127:0] isb, ark, imc;

    always_comb begin
        isb = inv_sub_bytes(inv_shift_rows(st));
        ark = isb ^ rk[rnd];
        imc = inv_mix_columns(ark);
    end

    always_ff @(posedge inClk or negedge inRstN) begin
        if (!inRstN) begin
            fsm      <= IDLE;
            outBusy  <= 1'b0;
            outValid <= 1'b0;
            outData  <= '0;
            st       <= '0;
            kcnt     <= '0;
            rnd      <= '0;
            pending  <= 1'b0;
            for (int i = 0; i < 15; i++) rk[i] <= '0;
        end else begin
            outValid <= 1'b0;
            case (fsm)
                IDLE: begin
                    if (inKeyWr) begin
                        rk[0]   <= inKeyData[255:128];
                        rk[1]   <= inKeyData[127:0];
                        kcnt    <= 4'd2;
                        fsm     <= KEXP;
                        outBusy <= 1'b1;
                        if (inDataWr) begin
                            st      <= inDataData;
                            pending <= 1'b1;
                        end
                    end else if (inDataWr) begin
                        st      <= inDataData;
                        pending <= 1'b1;
                        fsm     <= INIT;
                        outBusy <= 1'b1;
                    end
                end
                KEXP: begin
                    rk[kcnt] <= {kw0, kw1, kw2, kw3};
                    if (kcnt == 4'd14) begin
                        kcnt <= '0;
                        if (pending) begin
                            fsm <= INIT;
                        end else begin
                            fsm     <= IDLE;
                            outBusy <= 1'b0;
                        end
                    end else begin
                        kcnt <= kcnt + 4'd1;
                    end
                end
                INIT: begin
                    st  <= st ^ rk[14];
                    rnd <= 4'd13;
                    fsm <= ROUND;
                end
                ROUND: begin
                    if (rnd == 4'd0) begin
                        outData  <= ark;
                        outValid <= 1'b1;
                        pending  <= 1'b0;
                        outBusy  <= 1'b0;
                        fsm      <= IDLE;
                    end else begin
                        st  <= imc;
                        rnd <= rnd - 4'd1;
                    end
                end
                default: fsm <= IDLE;
            endcase
        end
    end

endmodule

// File: doc/aes_dec.md
AES_DEC -- requirements
Module: aes_dec

Interface
REQ-001 The block SHALL have no parameters; AES-256 only (Nk=8, Nr=14).
REQ-002 inClk  input  1  sole clock; all state updates on rising edge.
REQ-003 inRstN  input  1  asynchronous, active-low reset.
REQ-004 inKeyWr  input  1  key-load strobe, sampled on a rising edge.
REQ-005 inKeyData  input  256  cipher key, FIPS-197 byte order, first key byte in bits [255:248].
REQ-006 inDataWr  input  1  ciphertext-load strobe, sampled on a rising edge.
REQ-007 inDataData  input  128  ciphertext block, first byte in bits [127:120].
REQ-008 outData  output  128  last decrypted plaintext block, held until the next completion.
REQ-009 outBusy  output  1  high while a key expansion or decryption is in progress.
REQ-010 outValid  output  1  one-cycle pulse on the cycle that outData is updated.

Function
REQ-011 The block SHALL implement the FIPS-197 inverse cipher iteratively, one round per clock, using the same key/data strobe protocol as the encryptor.
REQ-012 The block SHALL hold 15 round keys rk0..rk14 (128 b each) in registers.
REQ-013 FSM states SHALL be IDLE, KEXP, INIT and ROUND.
REQ-014 IDLE with inKeyWr=1: rk0<=key[255:128], rk1<=key[127:0], counter<=2, go KEXP.
REQ-015 KEXP: on each edge compute rk[counter] by the standard AES-256 schedule (RotWord/SubWord/Rcon on even index, SubWord only on odd index); after rk14 (13 edges), go INIT if data is pending, else IDLE.
REQ-016 IDLE with inDataWr=1: latch inDataData into the state register, set data-pending, go INIT, unless inKeyWr=1 is also asserted, in which case also set data-pending and go KEXP.
REQ-017 INIT: state<=state^rk14, round<=13, go ROUND (1 edge).
REQ-018 ROUND, round 13..1: state<=InvMixColumns(AddRoundKey(InvSubBytes(InvShiftRows(state)), rk[round])), round decrements.
REQ-019 ROUND, round 0: outData<=InvSubBytes(InvShiftRows(state))^rk0, outValid=1 for that cycle, clear data-pending, go IDLE.
REQ-020 Latency, data-only: write edge E0, INIT at E1, output at E15; outBusy high from after E0 until E15, low after E15.
REQ-021 Latency, key and data written together: KEXP on E1..E13, INIT at E14, output at E28.
REQ-022 Key-only write: outBusy high for 13 cycles; outData and outValid unchanged.
REQ-023 Any inKeyWr or inDataWr asserted while outBusy=1 SHALL be ignored; there is no queueing.
REQ-024 A new inDataWr on the same edge that outBusy falls SHALL be ignored; the first accepted edge is the following one.
REQ-025 Round keys SHALL persist across decryptions until the next accepted inKeyWr.
REQ-026 inDataWr without any key ever loaded SHALL decrypt with all-zero round keys, with no error indication.
REQ-027 outBusy SHALL be registered; outValid and outBusy-fall SHALL occur on the same edge.

Reset
REQ-028 inRstN=0 SHALL immediately force: FSM to IDLE, outBusy=0, outValid=0, outData=0, rk0..rk14=0, data-pending=0, counters=0.
REQ-029 Reset asserted mid-KEXP or mid-ROUND SHALL abort the operation with no outValid pulse; the next operation after release SHALL behave as if from power-up.

Verification
REQ-030 Key 000102..1e1f plus data 8ea2b7ca516745bfeafc49904b496089 written together -> outData=00112233445566778899aabbccddeeff, outValid on E28, outBusy high for 28 cycles.
REQ-031 Same key retained, second block 8ea2b7ca516745bfeafc49904b496089 -> same plaintext, outValid on E15.
REQ-032 Round trip: 10 blocks produced by the encryptor's chained test (key <= {key[127:0], data}, data <= cipher) decrypted in reverse order -> each matches the original plaintext.
REQ-033 inDataWr and inKeyWr pulsed at E5 during a busy decryption -> ignored; original result and timing unchanged; rk registers unchanged.
REQ-034 inRstN low at E7 of a decryption -> outBusy=0 and outData=0 immediately, no outValid; a fresh key plus data after release decrypts correctly.
REQ-035 Key-only write -> outBusy high 13 cycles, no outValid, outData retains its previous value.
